// File: rtl/risc_pkg.sv
// Shared types and constants for the 8-bit RISC core: opcodes, sequencer states
// and the opcode position inside the instruction register.
package risc_pkg;
    localparam int OPC_W   = 3;
    localparam int ST_W    = 3;
    localparam int OPC_MSB = 15;

    typedef enum logic [OPC_W-1:0] {
        HLT  = 3'd0,
        SKZ  = 3'd1,
        ADD  = 3'd2,
        ANDD = 3'd3,
        XORR = 3'd4,
        LDA  = 3'd5,
        STO  = 3'd6,
        JMP  = 3'd7
    } opcode_e;

    typedef enum logic [ST_W-1:0] {
        S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
        S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
    } state_e;
endpackage

// File: rtl/machine_ena.sv
// Arming flop: set by the first fetch strobe after reset, held until rst drops.
module machine_ena (
    input  logic clk1,
    input  logic rst,
    input  logic fetch,
    output logic ena
);
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            ena <= 1'b0;
        end else if (fetch) begin
            ena <= 1'b1;
        end
    end
endmodule

// File: rtl/machine_ctl.sv
// Instruction-cycle sequencer: eight states per instruction, combinational strobe
// decode from state/opcode/zero, gated by the arming flop and the halt latch.
module machine_ctl
    import risc_pkg::*;
(
    input  logic             clk1,
    input  logic             rst,
    input  logic             fetch,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             rd,
    output logic             wr,
    output logic             load_acc,
    output logic             datactl_ena,
    output logic             halt,
    output logic [ST_W-1:0]  state
);
    logic    ena;
    state_e  state_reg;
    logic    halted_reg;
    opcode_e opc;

    assign opc   = opcode_e'(opcode);
    assign state = state_reg;

    machine_ena u_ena (
        .clk1  (clk1),
        .rst   (rst),
        .fetch (fetch),
        .ena   (ena)
    );

    // A HLT in S3 latches halted and leaves the state parked at S3.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_reg  <= S0;
            halted_reg <= 1'b0;
        end else if (ena && !halted_reg) begin
            if (state_reg == S3 && opc == HLT) begin
                halted_reg <= 1'b1;
            end else begin
                state_reg <= state_e'(state_reg + 3'd1);
            end
        end
    end

    always_comb begin
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        load_acc    = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;
        if (ena) begin
            if (halted_reg) begin
                halt = 1'b1;
            end else begin
                case (state_reg)
                    S0, S1: begin
                        rd      = 1'b1;
                        load_ir = 1'b1;
                        inc_pc  = 1'b1;
                    end
                    S3: halt = (opc == HLT);
                    S4: begin
                        case (opc)
                            ADD, ANDD, XORR, LDA: rd = 1'b1;
                            STO:                  datactl_ena = 1'b1;
                            JMP:                  load_pc = 1'b1;
                            default: ;
                        endcase
                    end
                    S5: begin
                        case (opc)
                            ADD, ANDD, XORR, LDA: begin
                                rd       = 1'b1;
                                load_acc = 1'b1;
                            end
                            STO: begin
                                wr          = 1'b1;
                                datactl_ena = 1'b1;
                            end
                            JMP:     load_pc = 1'b1;
                            SKZ:     inc_pc  = zero;
                            default: ;
                        endcase
                    end
                    S6: datactl_ena = (opc == STO);
                    // Second skip increment steps over both bytes of the next instruction.
                    S7: inc_pc = (opc == SKZ) && zero;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_machine_ctl.sv
// Self-checking bench for machine_ctl: expected strobe vectors are queued as
// stimulus is applied and compared on the following falling edge.
module tb_machine_ctl;
    logic       clk1 = 1'b0;
    logic       rst  = 1'b1;
    logic       fetch = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       load_ir, inc_pc, load_pc, rd, wr, load_acc, datactl_ena, halt;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    logic [10:0] sb[$];
    logic [10:0] got;
    logic [10:0] exp_v;

    machine_ctl dut (
        .clk1        (clk1),
        .rst         (rst),
        .fetch       (fetch),
        .opcode      (opcode),
        .zero        (zero),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .rd          (rd),
        .wr          (wr),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .state       (state)
    );

    always #5 clk1 = ~clk1;

    // {halt, load_ir, inc_pc, load_pc, rd, wr, load_acc, datactl_ena, state[2:0]}
    assign got = {halt, load_ir, inc_pc, load_pc, rd, wr, load_acc, datactl_ena, state};

    localparam logic [10:0] IDLE = 11'd0;
    localparam logic [10:0] HALTED = {1'b1, 7'b0, 3'd3};

    // Reference strobe table, written from the per-state description.
    function automatic logic [10:0] model(input int s, input logic [2:0] opc, input logic z);
        logic h, lir, ipc, lpc, r, w, lacc, dctl;
        logic [2:0] st;
        {h, lir, ipc, lpc, r, w, lacc, dctl} = 8'b0;
        st = s[2:0];
        case (s)
            0, 1: begin r = 1; lir = 1; ipc = 1; end
            3: h = (opc == 3'd0);
            4: begin
                if (opc >= 3'd2 && opc <= 3'd5) r = 1;
                if (opc == 3'd6) dctl = 1;
                if (opc == 3'd7) lpc = 1;
            end
            5: begin
                if (opc >= 3'd2 && opc <= 3'd5) begin r = 1; lacc = 1; end
                if (opc == 3'd6) begin w = 1; dctl = 1; end
                if (opc == 3'd7) lpc = 1;
                if (opc == 3'd1) ipc = z;
            end
            6: dctl = (opc == 3'd6);
            7: ipc = (opc == 3'd1) && z;
            default: ;
        endcase
        return {h, lir, ipc, lpc, r, w, lacc, dctl, st};
    endfunction

    // Exclusivity invariants sampled every cycle.
    always @(negedge clk1) begin
        if (rd && wr) begin
            bad++;
            $display("FAIL inv_rd_wr got rd=%b wr=%b want not both", rd, wr);
        end
        if (wr && !datactl_ena) begin
            bad++;
            $display("FAIL inv_wr_dctl got wr=%b datactl_ena=%b want dctl with wr", wr, datactl_ena);
        end
        if (load_pc && inc_pc) begin
            bad++;
            $display("FAIL inv_pc got load_pc=%b inc_pc=%b want not both", load_pc, inc_pc);
        end
    end

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        total++;
        if (got !== IDLE) begin
            bad++;
            $display("FAIL reset_async got=%h want=%h", got, IDLE);
        end
        for (int i = 0; i < 3; i++) begin
            fetch = (i == 1);
            sb.push_back(IDLE);
            @(negedge clk1);
            exp_v = sb.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL reset_hold c%0d got=%h want=%h", i, got, exp_v);
            end
        end
        fetch = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_arming();
        for (int i = 0; i < 5; i++) begin
            sb.push_back(IDLE);
            @(negedge clk1);
            exp_v = sb.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL arm_idle c%0d got=%h want=%h", i, got, exp_v);
            end
        end
        fetch = 1'b1;
        sb.push_back(model(0, opcode, zero));
        @(negedge clk1);
        fetch = 1'b0;
        exp_v = sb.pop_front();
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL arm_s0 got=%h want=%h", got, exp_v);
        end
    endtask

    // Runs S1..S7 and the following S0 of one instruction; returns inc_pc pulses in S0..S7.
    task automatic run_instr(input string name, input logic [2:0] opc, input logic z,
                             output int inc_cnt);
        opcode = opc;
        zero = z;
        inc_cnt = 1;
        for (int s = 1; s <= 8; s++) begin
            sb.push_back(model(s % 8, opc, z));
            @(negedge clk1);
            exp_v = sb.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL %s s%0d got=%h want=%h", name, s % 8, got, exp_v);
            end
            if (s < 8 && got[8]) inc_cnt++;
        end
    endtask

    task automatic test_add();
        int n;
        run_instr("add", 3'd2, 1'b0, n);
    endtask

    task automatic test_sto();
        int n;
        run_instr("sto", 3'd6, 1'b1, n);
    endtask

    task automatic test_skz();
        int n;
        run_instr("skz_z1", 3'd1, 1'b1, n);
        total++;
        if (n !== 4) begin
            bad++;
            $display("FAIL skz_z1_count got=%0d want=4", n);
        end
        run_instr("skz_z0", 3'd1, 1'b0, n);
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL skz_z0_count got=%0d want=2", n);
        end
    endtask

    task automatic test_jmp_halt();
        int n;
        run_instr("jmp", 3'd7, 1'b0, n);
        opcode = 3'd0;
        for (int s = 1; s <= 3; s++) begin
            sb.push_back(model(s, 3'd0, zero));
            @(negedge clk1);
            exp_v = sb.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL hlt s%0d got=%h want=%h", s, got, exp_v);
            end
        end
        for (int i = 0; i < 20; i++) begin
            fetch = i[0];
            sb.push_back(HALTED);
            @(negedge clk1);
            exp_v = sb.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL halted c%0d got=%h want=%h", i, got, exp_v);
            end
        end
        fetch = 1'b0;
    endtask

    task automatic test_reset_mid_sto();
        test_reset();
        test_arming();
        opcode = 3'd6;
        for (int s = 1; s <= 5; s++) begin
            sb.push_back(model(s, 3'd6, zero));
            @(negedge clk1);
            exp_v = sb.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL sto_pre s%0d got=%h want=%h", s, got, exp_v);
            end
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (got !== IDLE) begin
            bad++;
            $display("FAIL sto_abort got=%h want=%h", got, IDLE);
        end
        @(negedge clk1);
        rst = 1'b1;
        test_arming();
        test_sto();
    endtask

    initial begin
        test_reset();
        opcode = 3'd2;
        test_arming();
        test_add();
        test_sto();
        test_skz();
        test_add();
        test_jmp_halt();
        test_reset_mid_sto();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
